// File: rtl/time_bcd_converter_pkg.sv
// time_pkg: shared definitions for the time/date BCD register stage.
//   - field_e     : field index (sec, min, hour, day, month, year)
//   - NUM_FIELDS  : number of captured fields
//   - BCD_ERR     : digit code stored for an overflowing field (shown as 'E')
//   - state_e     : converter FSM states
//   - BCD_ITERS   : double-dabble iterations for a 16-bit input
//   - bcd_adjust  : add-3 correction applied to every digit >= 5
package time_pkg;

    typedef enum logic [2:0] {
        FIELD_SEC   = 3'd0,
        FIELD_MIN   = 3'd1,
        FIELD_HOUR  = 3'd2,
        FIELD_DAY   = 3'd3,
        FIELD_MONTH = 3'd4,
        FIELD_YEAR  = 3'd5
    } field_e;

    localparam int unsigned NUM_FIELDS = 6;
    localparam logic [3:0]  BCD_ERR    = 4'hA;
    localparam int unsigned BCD_ITERS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_STORE
    } state_e;

    function automatic logic [19:0] bcd_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int unsigned i = 0; i < 5; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/time_bcd_converter_if.sv
// time_bcd_converter_if: CPU output-port write bus.
//   write_out : write strobe (one write per cycle while high)
//   out_port  : port index (0 sec .. 5 year, 6..15 ignored)
//   out_data  : unsigned binary value
// Modports: master (CPU/driver side), slave (converter side).
interface time_bcd_converter_if #(
    parameter int DATA_W = 16
) ();
    logic              write_out;
    logic [3:0]        out_port;
    logic [DATA_W-1:0] out_data;

    modport master (output write_out, output out_port, output out_data);
    modport slave  (input  write_out, input  out_port, input  out_data);
endinterface

// File: rtl/time_bcd_converter_bin2bcd_serial.sv
// bin2bcd_serial: serial double-dabble engine, 16-bit binary to 5 BCD digits.
//   clk, reset : clock, synchronous active-high reset
//   start      : load din and begin a conversion (one BCD_ITERS-cycle run)
//   din        : binary input
//   done       : high in the cycle whose rising edge performs the last
//                iteration; bcd is final right after that edge
//   bcd        : 5 BCD digits, ten-thousands in [19:16]
module bin2bcd_serial
    import time_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] din,
    output logic        done,
    output logic [19:0] bcd
);

    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [19:0] adj;

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        adj   = bcd_adjust(bcd_q);
        if (start) begin
            bin_d = din;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            {bcd_d, bin_d} = {adj[18:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 5'd1;
            if (cnt_q == 5'(BCD_ITERS - 1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // Combinational so the controlling FSM can leave SHIFT on the same edge
    // that performs the final iteration.
    assign done = run_q && (cnt_q == 5'(BCD_ITERS - 1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/time_bcd_converter.sv
// time_bcd_converter: captures CPU writes to the six time/date ports, converts
// each pending field to BCD through one shared serial double-dabble engine and
// holds the digits for the 7-segment display.
//   clk, reset        : clock, synchronous active-high reset
//   wr (slave)        : write_out / out_port / out_data write bus
//   sec..month_bcd    : two BCD digits each, tens in [7:4]
//   year_bcd          : four BCD digits, thousands in [15:12]
//   busy              : conversion in progress
//   done, done_field  : one-cycle pulse and index of the field just updated
// Build option TIME_BCD_SATURATE_EN: overflowing fields store 0xA in every
// digit instead of the truncated low digits.
module time_bcd_converter
    import time_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    time_bcd_converter_if.slave  wr,
    output logic [7:0]           sec_bcd,
    output logic [7:0]           min_bcd,
    output logic [7:0]           hour_bcd,
    output logic [7:0]           day_bcd,
    output logic [7:0]           month_bcd,
    output logic [15:0]          year_bcd,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           done_field
);

`ifdef TIME_BCD_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e                 state_q, state_d;
    field_e                 sel_q, sel_d;
    logic [NUM_FIELDS-1:0]  pending_q, pending_d;
    logic [DATA_W-1:0]      value_q [NUM_FIELDS];
    logic [DATA_W-1:0]      value_d [NUM_FIELDS];
    logic [7:0]             bcd2_q [NUM_FIELDS-1];
    logic [7:0]             bcd2_d [NUM_FIELDS-1];
    logic [15:0]            year_q, year_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    field_e                 done_field_q, done_field_d;

    logic                   found;
    field_e                 low;
    logic                   eng_start;
    logic [15:0]            eng_din;
    logic                   eng_done;
    logic [19:0]            eng_bcd;
    logic [7:0]             two_val;
    logic [15:0]            year_val;

    bin2bcd_serial u_engine (
        .clk   (clk),
        .reset (reset),
        .start (eng_start),
        .din   (eng_din),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        pending_d    = pending_q;
        value_d      = value_q;
        bcd2_d       = bcd2_q;
        year_d       = year_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        done_field_d = done_field_q;
        eng_start    = 1'b0;
        found        = 1'b0;
        low          = FIELD_SEC;

        // Fixed-priority arbiter: lowest pending index wins.
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            if (!found && pending_q[i]) begin
                found = 1'b1;
                low   = field_e'(3'(i));
            end
        end
        eng_din = 16'(value_q[low]);

        year_val = (SAT_EN && (eng_bcd[19:16] != 4'd0)) ? {4{BCD_ERR}} : eng_bcd[15:0];
        two_val  = (SAT_EN && (eng_bcd[19:8] != 12'd0)) ? {2{BCD_ERR}} : eng_bcd[7:0];

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    sel_d          = low;
                    pending_d[low] = 1'b0;
                    eng_start      = 1'b1;
                    busy_d         = 1'b1;
                    state_d        = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (eng_done) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                if (sel_q == FIELD_YEAR) begin
                    year_d = year_val;
                end else begin
                    bcd2_d[sel_q] = two_val;
                end
                done_d       = 1'b1;
                done_field_d = sel_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Capture is applied after the arbiter's clear so a write landing on
        // the field being loaded keeps it pending for a second conversion.
        if (wr.write_out && (wr.out_port < 4'(NUM_FIELDS))) begin
            value_d[wr.out_port[2:0]]   = wr.out_data;
            pending_d[wr.out_port[2:0]] = 1'b1;
        end

        if (state_q == ST_STORE) begin
            busy_d = |pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= FIELD_SEC;
            pending_q    <= '0;
            value_q      <= '{default: '0};
            bcd2_q       <= '{default: '0};
            year_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_field_q <= FIELD_SEC;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            pending_q    <= pending_d;
            value_q      <= value_d;
            bcd2_q       <= bcd2_d;
            year_q       <= year_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            done_field_q <= done_field_d;
        end
    end

    assign sec_bcd    = bcd2_q[FIELD_SEC];
    assign min_bcd    = bcd2_q[FIELD_MIN];
    assign hour_bcd   = bcd2_q[FIELD_HOUR];
    assign day_bcd    = bcd2_q[FIELD_DAY];
    assign month_bcd  = bcd2_q[FIELD_MONTH];
    assign year_bcd   = year_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_field = done_field_q;

endmodule

// File: tb/tb_time_bcd_converter.sv
// tb_time_bcd_converter: directed, scoreboard-based bench for
// time_bcd_converter. Expected completions are queued as writes are driven and
// checked on every done pulse. Honors TIME_BCD_SATURATE_EN like the design.
module tb_time_bcd_converter;

`ifdef TIME_BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [2:0]  f;
        logic [15:0] bcd;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd;
    logic [15:0] year_bcd;
    logic        busy, done;
    logic [2:0]  done_field;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          d0;

    time_bcd_converter_if #(.DATA_W(16)) bus ();

    time_bcd_converter #(.DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (bus),
        .sec_bcd    (sec_bcd),
        .min_bcd    (min_bcd),
        .hour_bcd   (hour_bcd),
        .day_bcd    (day_bcd),
        .month_bcd  (month_bcd),
        .year_bcd   (year_bcd),
        .busy       (busy),
        .done       (done),
        .done_field (done_field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion by decimal arithmetic.
    function automatic logic [15:0] model(input int unsigned f, input int unsigned v);
        int unsigned x;
        x = v;
        if (f == 5) begin
            if (SAT && x > 9999) return 16'hAAAA;
            x = x % 10000;
        end else begin
            if (SAT && x > 99) return 16'h00AA;
            x = x % 100;
        end
        return 16'((((x / 1000) % 10) << 12) | (((x / 100) % 10) << 8) |
                   (((x / 10) % 10) << 4) | (x % 10));
    endfunction

    function automatic logic [15:0] field_out(input logic [2:0] f);
        case (f)
            3'd0:    return {8'h00, sec_bcd};
            3'd1:    return {8'h00, min_bcd};
            3'd2:    return {8'h00, hour_bcd};
            3'd3:    return {8'h00, day_bcd};
            3'd4:    return {8'h00, month_bcd};
            default: return year_bcd;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int unsigned f, input int unsigned v);
        exp_t e;
        e.f   = 3'(f);
        e.bcd = model(f, v);
        sb.push_back(e);
    endtask

    // Called at posedge+1; the write is sampled at the next rising edge.
    task automatic drive(input logic [3:0] p, input logic [15:0] d);
        bus.write_out = 1'b1;
        bus.out_port  = p;
        bus.out_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.write_out = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b0 && sb.size() == 0) ok = 1'b1;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    // Scoreboard monitor: every done pulse must match the next expected completion.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("done_field", 32'(done_field), 32'(e.f));
                check("field_bcd", 32'(field_out(e.f)), 32'(e.bcd));
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.write_out = 1'b0;
        bus.out_port  = 4'd0;
        bus.out_data  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sec",   32'(sec_bcd),    32'h0);
        check("rst_min",   32'(min_bcd),    32'h0);
        check("rst_hour",  32'(hour_bcd),   32'h0);
        check("rst_day",   32'(day_bcd),    32'h0);
        check("rst_month", 32'(month_bcd),  32'h0);
        check("rst_year",  32'(year_bcd),   32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        check("rst_done",  32'(done),       32'h0);
        check("rst_dfld",  32'(done_field), 32'h0);
        reset = 1'b0;

        // First conversion straight out of reset.
        push(3, 9);
        drive(4'd3, 16'd9);
        idle_bus();
        wait_idle(60, "wait_day");
        check("day_09", 32'(day_bcd), 32'h09);

        // Single field with cycle-accurate busy/done timing.
        push(2, 23);
        drive(4'd2, 16'd23);
        idle_bus();
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            check("busy_during", 32'(busy), 32'd1);
            check("done_early",  32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        check("done_edge18", 32'(done),       32'd1);
        check("dfld_edge18", 32'(done_field), 32'd2);
        check("hour_23",     32'(hour_bcd),   32'h23);
        check("busy_fall",   32'(busy),       32'd0);
        wait_idle(10, "wait_hour");

        // Year, then back-to-back writes while the engine is busy with it.
        d0 = done_cnt;
        push(5, 2024);
        push(0, 59);
        push(1, 7);
        push(4, 12);
        drive(4'd5, 16'd2024);
        drive(4'd4, 16'd12);
        drive(4'd0, 16'd59);
        drive(4'd1, 16'd7);
        idle_bus();
        wait_idle(200, "wait_b2b");
        check("b2b_done_count", 32'(done_cnt - d0), 32'd4);
        check("year_2024", 32'(year_bcd),  32'h2024);
        check("sec_59",    32'(sec_bcd),   32'h59);
        check("min_07",    32'(min_bcd),   32'h07);
        check("month_12",  32'(month_bcd), 32'h12);

        // Rewrite during SHIFT plus an ignored port.
        d0 = done_cnt;
        push(0, 30);
        push(0, 31);
        drive(4'd0, 16'd30);
        idle_bus();
        repeat (5) @(posedge clk);
        #1;
        drive(4'd0, 16'd31);
        drive(4'd9, 16'h0055);
        idle_bus();
        wait_idle(100, "wait_coll");
        check("coll_done_count", 32'(done_cnt - d0), 32'd2);
        check("sec_31",          32'(sec_bcd),       32'h31);
        check("min_unchanged",   32'(min_bcd),       32'h07);

        // Rewrite on the very edge the field is loaded: write wins.
        d0 = done_cnt;
        push(0, 40);
        push(0, 41);
        drive(4'd0, 16'd40);
        drive(4'd0, 16'd41);
        idle_bus();
        wait_idle(100, "wait_load_coll");
        check("load_coll_count", 32'(done_cnt - d0), 32'd2);
        check("sec_41",          32'(sec_bcd),       32'h41);

        // Overflow handling.
        push(0, 100);
        push(5, 12345);
        drive(4'd0, 16'd100);
        drive(4'd5, 16'd12345);
        idle_bus();
        wait_idle(100, "wait_ovf");
        check("sec_ovf",  32'(sec_bcd),  32'(model(0, 100)));
        check("year_ovf", 32'(year_bcd), 32'(model(5, 12345)));

        // Reset asserted at edge 8 of a conversion.
        d0 = done_cnt;
        drive(4'd1, 16'd45);
        idle_bus();
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_min",  32'(min_bcd),  32'h0);
        check("mid_year", 32'(year_bcd), 32'h0);
        check("mid_busy", 32'(busy),     32'd0);
        check("mid_done", 32'(done),     32'd0);
        repeat (30) @(posedge clk);
        #1;
        check("mid_no_done",  32'(done_cnt - d0), 32'd0);
        check("mid_idle",     32'(busy),          32'd0);
        check("mid_min_hold", 32'(min_bcd),       32'h0);
        check("sb_empty",     32'(sb.size()),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
